calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 107 ++++++++++
 tb/tb_calc_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Sequences operand A, operand B and an opcode into a combinational calculator,
// waits a fixed settle time, then holds the captured result until downstream takes it.
module calc_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] calc_a,
  output logic [3:0] calc_b,
  output logic [2:0] calc_oper,
  input  logic [7:0] calc_out,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_err,
  input  logic       res_ready,
  output logic [7:0] res_count
);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_OP, SETTLE, HOLD} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;
  logic       take;
  logic       settle_done;

  // Opcodes above mod are undefined; div and mod have no meaning for a zero divisor.
  function automatic logic result_err(input logic [2:0] oper, input logic [3:0] b);
    return (oper > 3'd4) || (((oper == 3'd3) || (oper == 3'd4)) && (b == 4'd0));
  endfunction

  assign take        = in_valid && in_ready;
  assign settle_done = (state == SETTLE) && (settle_cnt == SETTLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD_A;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = !rst;
        if (in_valid) state_next = LOAD_B;
      end
      LOAD_B: begin
        in_ready = !rst;
        if (in_valid) state_next = LOAD_OP;
      end
      LOAD_OP: begin
        in_ready = !rst;
        if (in_valid) state_next = SETTLE;
      end
      SETTLE:  if (settle_done) state_next = HOLD;
      HOLD:    if (res_ready) state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calc_a     <= 4'd0;
      calc_b     <= 4'd0;
      calc_oper  <= 3'd0;
      settle_cnt <= 4'd0;
      res_valid  <= 1'b0;
      res_data   <= 8'h00;
      res_err    <= 1'b0;
      res_count  <= 8'h00;
    end else begin
      case (state)
        LOAD_A: if (take) calc_a <= in_data;
        LOAD_B: if (take) calc_b <= in_data;
        LOAD_OP: begin
          if (take) begin
            calc_oper  <= in_data[2:0];
            settle_cnt <= 4'd0;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            res_valid <= 1'b1;
            res_err   <= result_err(calc_oper, calc_b);
            res_data  <= result_err(calc_oper, calc_b) ? 8'h00 : calc_out;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_count <= res_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Runs two sequencers (settle 1 and settle 4) on shared stimulus against an
// entry-level behavioural model, plus literal checks of known results.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       res_ready = 1'b0;

  logic       in_ready_w [2];
  logic       res_valid_w[2];
  logic       res_err_w  [2];
  logic [3:0] calc_a_w   [2];
  logic [3:0] calc_b_w   [2];
  logic [2:0] calc_oper_w[2];
  logic [7:0] calc_out_w [2];
  logic [7:0] res_data_w [2];
  logic [7:0] res_count_w[2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Calculator in 8-bit context; undefined cases return junk the DUT must mask.
  function automatic logic [7:0] arith(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    logic [7:0] x;
    logic [7:0] y;
    x = {4'd0, a};
    y = {4'd0, b};
    case (op)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x * y;
      3'd3:    return (y == 8'd0) ? 8'hFF : x / y;
      3'd4:    return (y == 8'd0) ? 8'h77 : x % y;
      default: return 8'hAA;
    endcase
  endfunction

  function automatic logic bad(input logic [2:0] op, input logic [3:0] b);
    return (op >= 3'd5) || ((op == 3'd3 || op == 3'd4) && b == 4'd0);
  endfunction

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  assign calc_out_w[0] = arith(calc_a_w[0], calc_b_w[0], calc_oper_w[0]);
  assign calc_out_w[1] = arith(calc_a_w[1], calc_b_w[1], calc_oper_w[1]);

  calc_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w[0]),
    .calc_a(calc_a_w[0]), .calc_b(calc_b_w[0]), .calc_oper(calc_oper_w[0]),
    .calc_out(calc_out_w[0]), .res_valid(res_valid_w[0]), .res_data(res_data_w[0]),
    .res_err(res_err_w[0]), .res_ready(res_ready), .res_count(res_count_w[0]));

  calc_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w[1]),
    .calc_a(calc_a_w[1]), .calc_b(calc_b_w[1]), .calc_oper(calc_oper_w[1]),
    .calc_out(calc_out_w[1]), .res_valid(res_valid_w[1]), .res_data(res_data_w[1]),
    .res_err(res_err_w[1]), .res_ready(res_ready), .res_count(res_count_w[1]));

  // Model: entry index, remaining settle cycles, pending result.
  int         m_n   [2];
  int         m_wait[2];
  logic       m_valid[2];
  logic       m_err [2];
  logic [7:0] m_data[2];
  logic [7:0] m_count[2];
  logic [3:0] m_a[2];
  logic [3:0] m_b[2];
  logic [2:0] m_op[2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_n[i] <= 0; m_wait[i] <= 0; m_valid[i] <= 1'b0; m_err[i] <= 1'b0;
        m_data[i] <= 8'h00; m_count[i] <= 8'h00;
        m_a[i] <= 4'd0; m_b[i] <= 4'd0; m_op[i] <= 3'd0;
      end else if (m_valid[i]) begin
        if (res_ready) begin
          m_valid[i] <= 1'b0;
          m_count[i] <= m_count[i] + 8'd1;
        end
      end else if (m_wait[i] > 0) begin
        m_wait[i] <= m_wait[i] - 1;
        if (m_wait[i] == 1) begin
          m_valid[i] <= 1'b1;
          m_err[i]   <= bad(m_op[i], m_b[i]);
          m_data[i]  <= bad(m_op[i], m_b[i]) ? 8'h00 : arith(m_a[i], m_b[i], m_op[i]);
        end
      end else if (in_valid) begin
        case (m_n[i])
          0:       m_a[i] <= in_data;
          1:       m_b[i] <= in_data;
          default: begin m_op[i] <= in_data[2:0]; m_wait[i] <= settle_of(i); end
        endcase
        m_n[i] <= (m_n[i] + 1) % 3;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (in_ready_w[i] !== (!rst && !m_valid[i] && m_wait[i] == 0) ||
          res_valid_w[i] !== m_valid[i] || res_data_w[i] !== m_data[i] ||
          res_err_w[i] !== m_err[i] || res_count_w[i] !== m_count[i] ||
          calc_a_w[i] !== m_a[i] || calc_b_w[i] !== m_b[i] || calc_oper_w[i] !== m_op[i]) begin
        fails++;
        $display("FAIL cycle_check dut%0d t=%0t got/exp: valid %b/%b data %h/%h err %b/%b cnt %h/%h a %h/%h b %h/%h op %h/%h ready %b",
                 settle_of(i), $time, res_valid_w[i], m_valid[i], res_data_w[i], m_data[i],
                 res_err_w[i], m_err[i], res_count_w[i], m_count[i], calc_a_w[i], m_a[i],
                 calc_b_w[i], m_b[i], calc_oper_w[i], m_op[i], in_ready_w[i]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input int gap);
    int n;
    repeat (gap) begin
      in_valid  = 1'b0;
      res_ready = 1'($urandom_range(0, 1));
      tick();
    end
    res_ready = 1'b0;
    n = 0;
    while (!(in_ready_w[0] && in_ready_w[1]) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 4'($urandom);
  endtask

  // Issues one operation and waits with res_ready low until both results are up.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input int gap, input int hold,
                        output logic [7:0] d0, output logic [7:0] d1,
                        output logic e0, output logic e1);
    int edges;
    int lat[2];
    edges = 0;
    lat[0] = 0;
    lat[1] = 0;
    send(a, gap);
    send(b, gap);
    send(op, gap);
    while (!(res_valid_w[0] && res_valid_w[1]) && edges < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'($urandom);
      tick();
      edges++;
      for (int i = 0; i < 2; i++)
        if (res_valid_w[i] && lat[i] == 0) lat[i] = edges + 1;
    end
    for (int i = 0; i < 2; i++)
      check($sformatf("latency_dut%0d", settle_of(i)), 32'(lat[i]), 32'(settle_of(i) + 1));
    d0 = res_data_w[0];
    d1 = res_data_w[1];
    e0 = res_err_w[0];
    e1 = res_err_w[1];
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'($urandom);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [7:0] d0, input logic [7:0] d1,
                              input logic e0, input logic e1,
                              input logic [7:0] exp_d, input logic exp_e);
    check({name, "_data1"}, 32'(d0), 32'(exp_d));
    check({name, "_data4"}, 32'(d1), 32'(exp_d));
    check({name, "_err1"}, 32'(e0), 32'(exp_e));
    check({name, "_err4"}, 32'(e1), 32'(exp_e));
  endtask

  task automatic check_reset_outputs(input string name);
    for (int i = 0; i < 2; i++) begin
      check({name, "_ready"}, 32'(in_ready_w[i]), 32'd0);
      check({name, "_valid"}, 32'(res_valid_w[i]), 32'd0);
      check({name, "_count"}, 32'(res_count_w[i]), 32'd0);
      check({name, "_data"}, 32'(res_data_w[i]), 32'd0);
      check({name, "_ops"}, {21'd0, res_err_w[i], calc_a_w[i], calc_b_w[i], calc_oper_w[i]}, 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d0, d1;
    logic       e0, e1;
    logic [3:0] ra, rb;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("ready_after_reset1", 32'(in_ready_w[0]), 32'd1);
    check("ready_after_reset4", 32'(in_ready_w[1]), 32'd1);

    run_op(4'h3, 4'h5, 4'h0, 0, 0, d0, d1, e0, e1);
    check_result("add", d0, d1, e0, e1, 8'h08, 1'b0);
    check("count_before", 32'(res_count_w[0]), 32'd0);
    release_res();
    check("count_after1", 32'(res_count_w[0]), 32'd1);
    check("count_after4", 32'(res_count_w[1]), 32'd1);

    run_op(4'h2, 4'h5, 4'h1, 1, 1, d0, d1, e0, e1);
    check_result("sub", d0, d1, e0, e1, 8'hFD, 1'b0);
    release_res();
    run_op(4'hF, 4'hF, 4'hA, 2, 0, d0, d1, e0, e1);
    check_result("mul", d0, d1, e0, e1, 8'hE1, 1'b0);
    release_res();
    run_op(4'h7, 4'h0, 4'h3, 0, 2, d0, d1, e0, e1);
    check_result("div0", d0, d1, e0, e1, 8'h00, 1'b1);
    release_res();
    run_op(4'h7, 4'h2, 4'h5, 0, 0, d0, d1, e0, e1);
    check_result("illegal", d0, d1, e0, e1, 8'h00, 1'b1);
    release_res();

    run_op(4'h9, 4'h4, 4'h4, 0, 6, d0, d1, e0, e1);
    check("bp_valid", 32'(res_valid_w[1]), 32'd1);
    check("bp_data", 32'(res_data_w[1]), 32'h01);
    check("bp_ready", 32'(in_ready_w[1]), 32'd0);
    release_res();
    check("bp_valid_cleared", 32'(res_valid_w[1]), 32'd0);
    check("bp_data_kept", 32'(res_data_w[1]), 32'h01);

    send(4'h6, 0);
    send(4'h2, 1);
    rst = 1'b1;
    #2;
    check_reset_outputs("midreset");
    tick();
    rst = 1'b0;
    tick();
    run_op(4'h1, 4'h1, 4'h0, 0, 0, d0, d1, e0, e1);
    check_result("after_reset", d0, d1, e0, e1, 8'h02, 1'b0);
    release_res();
    check("after_reset_count", 32'(res_count_w[0]), 32'd1);

    repeat (40) begin
      ra = 4'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      run_op(ra, rb, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), d0, d1, e0, e1);
      release_res();
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    repeat (256) begin
      run_op(4'($urandom), 4'($urandom), 4'($urandom_range(0, 4)), 0, 0, d0, d1, e0, e1);
      release_res();
    end
    check("wrap_count1", 32'(res_count_w[0]), 32'd0);
    check("wrap_count4", 32'(res_count_w[1]), 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
